pipe_id_regfwd: RTL and testbench

Decode-stage register file with operand forwarding and load-use interlock for the five-stage pipelined CPU. It is the consumer end of the execute-stage result path: it accepts the execute result and destination register (ern/ealu, already jal-adjusted to r31/PC+8), the memory-stage result and the writeback write. It returns resolved rs/rt operands and the pipeline stall signal. It holds the 32×32 architectural register file and a stall-cycle performance counter.

---
 rtl/pipe_id_regfwd.sv | 109 ++++++++++
 tb/tb_pipe_id_regfwd.sv | 289 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pipe_id_regfwd.sv
// Decode-stage register file with EXE/MEM operand forwarding, load-use interlock
// and a saturating stall counter. Forwarding is enabled by defining PIPE_FWD_EN.
module pipe_id_regfwd (
   input  logic        clock,
   input  logic        resetn,
   input  logic [4:0]  rs,
   input  logic [4:0]  rt,
   input  logic        use_rs,
   input  logic        use_rt,
   input  logic [4:0]  ern,
   input  logic        ewreg,
   input  logic        em2reg,
   input  logic [31:0] ealu,
   input  logic [4:0]  mrn,
   input  logic        mwreg,
   input  logic        mm2reg,
   input  logic [31:0] malu,
   input  logic [31:0] mmo,
   input  logic [4:0]  wrn,
   input  logic        wwreg,
   input  logic [31:0] wdi,
   output logic [31:0] da,
   output logic [31:0] db,
   output logic [1:0]  fwda,
   output logic [1:0]  fwdb,
   output logic        wpcir,
   output logic [31:0] stall_cnt
);

   logic [31:0] regs [0:31];
   logic [31:0] rf_a, rf_b;
   logic        e_hit_a, e_hit_b, m_hit_a, m_hit_b;
   logic        hazard;

   always_ff @(posedge clock or negedge resetn) begin
      if (!resetn) begin
         for (int i = 0; i < 32; i++) regs[i] <= '0;
      end else if (wwreg && (wrn != 5'd0)) begin
         regs[wrn] <= wdi;
      end
   end

   // Regfile read path: r0 is hardwired, a same-cycle WB write bypasses the array.
   always_comb begin
      rf_a = regs[rs];
      if (rs == 5'd0) rf_a = '0;
      else if (wwreg && (wrn == rs)) rf_a = wdi;
      rf_b = regs[rt];
      if (rt == 5'd0) rf_b = '0;
      else if (wwreg && (wrn == rt)) rf_b = wdi;
   end

   assign e_hit_a = ewreg && (ern != 5'd0) && (ern == rs);
   assign e_hit_b = ewreg && (ern != 5'd0) && (ern == rt);
   assign m_hit_a = mwreg && (mrn != 5'd0) && (mrn == rs);
   assign m_hit_b = mwreg && (mrn != 5'd0) && (mrn == rt);

`ifdef PIPE_FWD_EN
   // EXE outranks MEM, MEM outranks the regfile/write-through path.
   always_comb begin
      da   = rf_a;
      fwda = 2'd0;
      if (e_hit_a) begin
         da   = ealu;
         fwda = 2'd1;
      end else if (m_hit_a) begin
         da   = mm2reg ? mmo : malu;
         fwda = mm2reg ? 2'd3 : 2'd2;
      end
      db   = rf_b;
      fwdb = 2'd0;
      if (e_hit_b) begin
         db   = ealu;
         fwdb = 2'd1;
      end else if (m_hit_b) begin
         db   = mm2reg ? mmo : malu;
         fwdb = mm2reg ? 2'd3 : 2'd2;
      end
   end

   // Only a load still in EXE cannot be forwarded yet.
   assign hazard = em2reg && ((use_rs && e_hit_a) || (use_rt && e_hit_b));
`else
   // Without bypass paths every in-flight producer of a used operand must drain.
   logic unused_fwd_inputs;
   assign unused_fwd_inputs = ^{ealu, malu, mmo, em2reg, mm2reg};

   always_comb begin
      da   = rf_a;
      db   = rf_b;
      fwda = 2'd0;
      fwdb = 2'd0;
   end

   assign hazard = (use_rs && (e_hit_a || m_hit_a)) ||
                   (use_rt && (e_hit_b || m_hit_b));
`endif

   assign wpcir = !hazard;

   always_ff @(posedge clock or negedge resetn) begin
      if (!resetn) begin
         stall_cnt <= '0;
      end else if (hazard && (stall_cnt != 32'hFFFF_FFFF)) begin
         stall_cnt <= stall_cnt + 32'd1;
      end
   end

endmodule

// File: tb/tb_pipe_id_regfwd.sv
// Self-checking bench for pipe_id_regfwd; expectations follow PIPE_FWD_EN as the RTL is built.
module tb_pipe_id_regfwd;

`ifdef PIPE_FWD_EN
   localparam bit FWD = 1'b1;
`else
   localparam bit FWD = 1'b0;
`endif

   logic        clock = 1'b0;
   logic        resetn;
   logic [4:0]  rs, rt, ern, mrn, wrn;
   logic        use_rs, use_rt, ewreg, em2reg, mwreg, mm2reg, wwreg;
   logic [31:0] ealu, malu, mmo, wdi;
   logic [31:0] da, db, stall_cnt;
   logic [1:0]  fwda, fwdb;
   logic        wpcir;

   typedef struct {
      logic [4:0]  rs, rt;
      logic        use_rs, use_rt;
      logic [4:0]  ern;
      logic        ewreg, em2reg;
      logic [31:0] ealu;
      logic [4:0]  mrn;
      logic        mwreg, mm2reg;
      logic [31:0] malu, mmo;
      logic [4:0]  wrn;
      logic        wwreg;
      logic [31:0] wdi;
   } stim_t;

   // mda/mdb mark an operand whose value is don't-care (load still in EXE).
   typedef struct {
      logic [31:0] da, db;
      logic [1:0]  fa, fb;
      logic        wp;
      logic        mda, mdb;
      string       name;
   } exp_t;

   exp_t        sb[$];
   int          n_checks = 0;
   int          n_fail = 0;
   logic [31:0] exp_cnt = 32'd0;

   pipe_id_regfwd dut (
      .clock(clock), .resetn(resetn),
      .rs(rs), .rt(rt), .use_rs(use_rs), .use_rt(use_rt),
      .ern(ern), .ewreg(ewreg), .em2reg(em2reg), .ealu(ealu),
      .mrn(mrn), .mwreg(mwreg), .mm2reg(mm2reg), .malu(malu), .mmo(mmo),
      .wrn(wrn), .wwreg(wwreg), .wdi(wdi),
      .da(da), .db(db), .fwda(fwda), .fwdb(fwdb), .wpcir(wpcir),
      .stall_cnt(stall_cnt)
   );

   always #5 clock = ~clock;

   function automatic stim_t idle();
      stim_t s;
      s.rs = '0; s.rt = '0; s.use_rs = 1'b0; s.use_rt = 1'b0;
      s.ern = '0; s.ewreg = 1'b0; s.em2reg = 1'b0; s.ealu = '0;
      s.mrn = '0; s.mwreg = 1'b0; s.mm2reg = 1'b0; s.malu = '0; s.mmo = '0;
      s.wrn = '0; s.wwreg = 1'b0; s.wdi = '0;
      return s;
   endfunction

   task automatic apply(input stim_t s);
      rs = s.rs; rt = s.rt; use_rs = s.use_rs; use_rt = s.use_rt;
      ern = s.ern; ewreg = s.ewreg; em2reg = s.em2reg; ealu = s.ealu;
      mrn = s.mrn; mwreg = s.mwreg; mm2reg = s.mm2reg; malu = s.malu; mmo = s.mmo;
      wrn = s.wrn; wwreg = s.wwreg; wdi = s.wdi;
   endtask

   task automatic test_reset();
      stim_t s;
      stim_t st[$];
      exp_t  ex[$];
      exp_t  e;
      logic [68:0] act, want;
      s = idle(); s.rs = 5'd5; s.use_rs = 1'b1;
      resetn = 1'b0;
      apply(s);
      #2;
      n_checks++;
      if (stall_cnt !== 32'd0 || da !== 32'd0) begin
         n_fail++;
         $display("FAIL reset_state: got da=%h stall_cnt=%h, expected 0 and 0", da, stall_cnt);
      end
      @(posedge clock); @(posedge clock); #2;
      resetn = 1'b1;
      s = idle(); s.rs = 5'd5; s.use_rs = 1'b1; s.wrn = 5'd5; s.wwreg = 1'b1; s.wdi = 32'h1234;
      st.push_back(s); ex.push_back('{32'h1234, 32'h0, 2'd0, 2'd0, 1'b1, 1'b0, 1'b0, "wb_r5_through"});
      s = idle(); s.rs = 5'd5; s.use_rs = 1'b1;
      st.push_back(s); ex.push_back('{32'h1234, 32'h0, 2'd0, 2'd0, 1'b1, 1'b0, 1'b0, "wb_r5_array"});
      for (int i = 0; i < st.size(); i++) begin
         apply(st[i]);
         sb.push_back(ex[i]);
         #2;
         e = sb.pop_front();
         act  = {e.mda ? 32'h0 : da, e.mdb ? 32'h0 : db, e.mda ? 2'd0 : fwda, e.mdb ? 2'd0 : fwdb, wpcir};
         want = {e.mda ? 32'h0 : e.da, e.mdb ? 32'h0 : e.db, e.mda ? 2'd0 : e.fa, e.mdb ? 2'd0 : e.fb, e.wp};
         n_checks++;
         if (act !== want) begin
            n_fail++;
            $display("FAIL %s: got {da,db,fwda,fwdb,wpcir}=%h, expected %h", e.name, act, want);
         end
         @(posedge clock);
         if (!e.wp) exp_cnt++;
         #2;
      end
   endtask

   task automatic test_write_through();
      stim_t s;
      stim_t st[$];
      exp_t  ex[$];
      exp_t  e;
      logic [68:0] act, want;
      s = idle(); s.rs = 5'd7; s.rt = 5'd7; s.use_rs = 1'b1; s.use_rt = 1'b1;
      s.wrn = 5'd7; s.wwreg = 1'b1; s.wdi = 32'hDEADBEEF;
      st.push_back(s); ex.push_back('{32'hDEADBEEF, 32'hDEADBEEF, 2'd0, 2'd0, 1'b1, 1'b0, 1'b0, "wt_r7"});
      s = idle(); s.rs = 5'd7; s.rt = 5'd5; s.use_rs = 1'b1; s.use_rt = 1'b1;
      st.push_back(s); ex.push_back('{32'hDEADBEEF, 32'h1234, 2'd0, 2'd0, 1'b1, 1'b0, 1'b0, "array_r7_r5"});
      s = idle(); s.use_rs = 1'b1; s.use_rt = 1'b1; s.wrn = 5'd0; s.wwreg = 1'b1; s.wdi = 32'hFFFFFFFF;
      st.push_back(s); ex.push_back('{32'h0, 32'h0, 2'd0, 2'd0, 1'b1, 1'b0, 1'b0, "wt_r0_ignored"});
      s = idle(); s.rt = 5'd7; s.use_rs = 1'b1; s.use_rt = 1'b1;
      st.push_back(s); ex.push_back('{32'h0, 32'hDEADBEEF, 2'd0, 2'd0, 1'b1, 1'b0, 1'b0, "array_r0_zero"});
      for (int i = 0; i < st.size(); i++) begin
         apply(st[i]);
         sb.push_back(ex[i]);
         #2;
         e = sb.pop_front();
         act  = {e.mda ? 32'h0 : da, e.mdb ? 32'h0 : db, e.mda ? 2'd0 : fwda, e.mdb ? 2'd0 : fwdb, wpcir};
         want = {e.mda ? 32'h0 : e.da, e.mdb ? 32'h0 : e.db, e.mda ? 2'd0 : e.fa, e.mdb ? 2'd0 : e.fb, e.wp};
         n_checks++;
         if (act !== want) begin
            n_fail++;
            $display("FAIL %s: got {da,db,fwda,fwdb,wpcir}=%h, expected %h", e.name, act, want);
         end
         @(posedge clock);
         if (!e.wp) exp_cnt++;
         #2;
         n_checks++;
         if (stall_cnt !== exp_cnt) begin
            n_fail++;
            $display("FAIL %s_stall_cnt: got %0d, expected %0d", e.name, stall_cnt, exp_cnt);
         end
      end
   endtask

   task automatic test_forward();
      stim_t s;
      stim_t st[$];
      exp_t  ex[$];
      exp_t  e;
      logic [68:0] act, want;
      s = idle(); s.rs = 5'd3; s.rt = 5'd7; s.use_rs = 1'b1; s.use_rt = 1'b1;
      s.ern = 5'd3; s.ewreg = 1'b1; s.ealu = 32'h55; s.mrn = 5'd3; s.mwreg = 1'b1; s.malu = 32'h66;
      st.push_back(s);
      ex.push_back('{FWD ? 32'h55 : 32'h0, 32'hDEADBEEF, FWD ? 2'd1 : 2'd0, 2'd0, FWD, 1'b0, 1'b0, "exe_over_mem"});
      s = idle(); s.rs = 5'd9; s.rt = 5'd5; s.use_rs = 1'b1; s.use_rt = 1'b1;
      s.mrn = 5'd9; s.mwreg = 1'b1; s.malu = 32'h66; s.wrn = 5'd9; s.wwreg = 1'b1; s.wdi = 32'h77;
      st.push_back(s);
      ex.push_back('{FWD ? 32'h66 : 32'h77, 32'h1234, FWD ? 2'd2 : 2'd0, 2'd0, FWD, 1'b0, 1'b0, "mem_over_wb"});
      s = idle(); s.rs = 5'd9; s.rt = 5'd9; s.use_rs = 1'b1; s.use_rt = 1'b1;
      s.mrn = 5'd9; s.mwreg = 1'b1; s.mm2reg = 1'b1; s.malu = 32'h66; s.mmo = 32'hA5;
      st.push_back(s);
      ex.push_back('{FWD ? 32'hA5 : 32'h77, FWD ? 32'hA5 : 32'h77, FWD ? 2'd3 : 2'd0, FWD ? 2'd3 : 2'd0, FWD, 1'b0, 1'b0, "mem_load_both"});
      s = idle(); s.rs = 5'd2; s.use_rs = 1'b1; s.ern = 5'd2; s.ewreg = 1'b1; s.ealu = 32'h11;
      st.push_back(s);
      ex.push_back('{FWD ? 32'h11 : 32'h0, 32'h0, FWD ? 2'd1 : 2'd0, 2'd0, FWD, 1'b0, 1'b0, "alu_dep_exe"});
      s = idle(); s.rs = 5'd2; s.use_rs = 1'b1; s.mrn = 5'd2; s.mwreg = 1'b1; s.malu = 32'h11;
      st.push_back(s);
      ex.push_back('{FWD ? 32'h11 : 32'h0, 32'h0, FWD ? 2'd2 : 2'd0, 2'd0, FWD, 1'b0, 1'b0, "alu_dep_mem"});
      s = idle(); s.rs = 5'd2; s.use_rs = 1'b1;
      st.push_back(s);
      ex.push_back('{32'h0, 32'h0, 2'd0, 2'd0, 1'b1, 1'b0, 1'b0, "alu_dep_drained"});
      for (int i = 0; i < st.size(); i++) begin
         apply(st[i]);
         sb.push_back(ex[i]);
         #2;
         e = sb.pop_front();
         act  = {e.mda ? 32'h0 : da, e.mdb ? 32'h0 : db, e.mda ? 2'd0 : fwda, e.mdb ? 2'd0 : fwdb, wpcir};
         want = {e.mda ? 32'h0 : e.da, e.mdb ? 32'h0 : e.db, e.mda ? 2'd0 : e.fa, e.mdb ? 2'd0 : e.fb, e.wp};
         n_checks++;
         if (act !== want) begin
            n_fail++;
            $display("FAIL %s: got {da,db,fwda,fwdb,wpcir}=%h, expected %h", e.name, act, want);
         end
         @(posedge clock);
         if (!e.wp) exp_cnt++;
         #2;
         n_checks++;
         if (stall_cnt !== exp_cnt) begin
            n_fail++;
            $display("FAIL %s_stall_cnt: got %0d, expected %0d", e.name, stall_cnt, exp_cnt);
         end
      end
   endtask

   task automatic test_load_use();
      stim_t s;
      stim_t st[$];
      exp_t  ex[$];
      exp_t  e;
      logic [68:0] act, want;
      s = idle(); s.rs = 5'd5; s.rt = 5'd4; s.use_rs = 1'b1; s.use_rt = 1'b1;
      s.ern = 5'd4; s.ewreg = 1'b1; s.em2reg = 1'b1; s.ealu = 32'hBAD;
      st.push_back(s);
      ex.push_back('{32'h1234, 32'h0, 2'd0, 2'd0, 1'b0, 1'b0, 1'b1, "load_use_stall"});
      s = idle(); s.rt = 5'd4; s.use_rt = 1'b1; s.mrn = 5'd4; s.mwreg = 1'b1; s.mm2reg = 1'b1; s.mmo = 32'hA5;
      st.push_back(s);
      ex.push_back('{32'h0, FWD ? 32'hA5 : 32'h0, 2'd0, FWD ? 2'd3 : 2'd0, FWD, 1'b0, 1'b0, "load_use_mem_fwd"});
      s = idle(); s.rt = 5'd4; s.use_rs = 1'b1; s.use_rt = 1'b0; s.ern = 5'd4; s.ewreg = 1'b1; s.em2reg = 1'b1;
      st.push_back(s);
      ex.push_back('{32'h0, 32'h0, 2'd0, 2'd0, 1'b1, 1'b0, 1'b1, "load_unused_rt"});
      s = idle(); s.use_rs = 1'b1; s.use_rt = 1'b1; s.ern = 5'd0; s.ewreg = 1'b1; s.ealu = 32'h33;
      st.push_back(s);
      ex.push_back('{32'h0, 32'h0, 2'd0, 2'd0, 1'b1, 1'b0, 1'b0, "exe_r0_ignored"});
      s = idle(); s.rs = 5'd6; s.use_rs = 1'b1; s.ern = 5'd6; s.ewreg = 1'b1; s.em2reg = 1'b1;
      s.mrn = 5'd6; s.mwreg = 1'b1; s.malu = 32'h44;
      st.push_back(s);
      ex.push_back('{32'h0, 32'h0, 2'd0, 2'd0, 1'b0, 1'b1, 1'b0, "load_beats_mem"});
      for (int i = 0; i < st.size(); i++) begin
         apply(st[i]);
         sb.push_back(ex[i]);
         #2;
         e = sb.pop_front();
         act  = {e.mda ? 32'h0 : da, e.mdb ? 32'h0 : db, e.mda ? 2'd0 : fwda, e.mdb ? 2'd0 : fwdb, wpcir};
         want = {e.mda ? 32'h0 : e.da, e.mdb ? 32'h0 : e.db, e.mda ? 2'd0 : e.fa, e.mdb ? 2'd0 : e.fb, e.wp};
         n_checks++;
         if (act !== want) begin
            n_fail++;
            $display("FAIL %s: got {da,db,fwda,fwdb,wpcir}=%h, expected %h", e.name, act, want);
         end
         @(posedge clock);
         if (!e.wp) exp_cnt++;
         #2;
         n_checks++;
         if (stall_cnt !== exp_cnt) begin
            n_fail++;
            $display("FAIL %s_stall_cnt: got %0d, expected %0d", e.name, stall_cnt, exp_cnt);
         end
      end
   endtask

   task automatic test_reset_mid();
      stim_t s;
      s = idle(); s.rs = 5'd5; s.rt = 5'd7; s.use_rs = 1'b1; s.use_rt = 1'b1;
      s.wrn = 5'd6; s.wwreg = 1'b1; s.wdi = 32'h9999;
      apply(s);
      #1;
      n_checks++;
      if (da !== 32'h1234 || db !== 32'hDEADBEEF) begin
         n_fail++;
         $display("FAIL pre_reset_regs: got da=%h db=%h, expected 00001234 deadbeef", da, db);
      end
      resetn = 1'b0;
      exp_cnt = 32'd0;
      #1;
      n_checks++;
      if (da !== 32'h0 || db !== 32'h0 || stall_cnt !== 32'h0) begin
         n_fail++;
         $display("FAIL async_reset: got da=%h db=%h stall_cnt=%h, expected all 0", da, db, stall_cnt);
      end
      @(posedge clock); #2;
      resetn = 1'b1;
      s = idle(); s.rs = 5'd6; s.rt = 5'd5; s.use_rs = 1'b1; s.use_rt = 1'b1;
      apply(s);
      #2;
      n_checks++;
      if (da !== 32'h0 || db !== 32'h0 || stall_cnt !== 32'h0) begin
         n_fail++;
         $display("FAIL wb_lost_in_reset: got da=%h db=%h stall_cnt=%h, expected all 0", da, db, stall_cnt);
      end
   endtask

   initial begin
      test_reset();
      test_write_through();
      test_forward();
      test_load_use();
      test_reset_mid();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
